// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan_nx1 selector family.
//   mode_e  : encoding of the mode input (manual select / scan)
//   state_e : sequencer states
//   clog2   : ceiling log2 with a floor of 1, for index and counter widths
package mux_scan_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_SCAN   = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  // Never returns 0, so a 1-channel or 1-cycle configuration still gets a
  // legal 1-bit vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_nx1_if.sv
// Bus bundle between a driver and mux_scan_nx1.
//   in_bus  : N_CH*W flattened channels, channel k at [k*W +: W]
//   sel     : manual channel select
//   mode    : 0 = manual, 1 = scan
//   hold    : freezes the scan index and dwell counter
//   out     : registered selected channel
//   cur_sel : index of the channel currently on out
//   wrap    : one-cycle pulse on the first channel-0 cycle after a full sweep
//   ch_mask : per-channel scan enable (only with MUX_SCAN_MASK_EN defined)
// Modports: master = driver side, slave = selector side.
interface mux_scan_nx1_if
  import mux_scan_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W    = 1
);
  localparam int SEL_W = clog2(N_CH);

  logic [N_CH*W-1:0] in_bus;
  logic [SEL_W-1:0]  sel;
  logic              mode;
  logic              hold;
  logic [W-1:0]      out;
  logic [SEL_W-1:0]  cur_sel;
  logic              wrap;

`ifdef MUX_SCAN_MASK_EN
  logic [N_CH-1:0]   ch_mask;

  modport master (
    output in_bus, sel, mode, hold, ch_mask,
    input  out, cur_sel, wrap
  );

  modport slave (
    input  in_bus, sel, mode, hold, ch_mask,
    output out, cur_sel, wrap
  );
`else
  modport master (
    output in_bus, sel, mode, hold,
    input  out, cur_sel, wrap
  );

  modport slave (
    input  in_bus, sel, mode, hold,
    output out, cur_sel, wrap
  );
`endif

endinterface

// File: rtl/mux_nx1.sv
// Combinational N_CH x W channel selector.
//   in_bus : flattened channels, channel k at [k*W +: W]
//   idx    : channel index; any value >= N_CH yields 0
//   y      : selected channel
module mux_nx1 #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = 3
) (
  input  logic [N_CH*W-1:0] in_bus,
  input  logic [SEL_W-1:0]  idx,
  output logic [W-1:0]      y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(idx) == k) y = in_bus[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N_CH-to-1 selector with manual and scanning modes.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : mux_scan_nx1_if slave (in_bus, sel, mode, hold -> out, cur_sel, wrap)
// Manual mode presents channel sel one cycle later. Scan mode steps an
// internal index through the channels, DWELL cycles each; hold freezes the
// index and dwell counter while out keeps tracking live data.
// Optional build macro MUX_SCAN_MASK_EN adds bus.ch_mask: the scan skips
// disabled channels, and an all-zero mask parks the index with out forced to 0.
module mux_scan_nx1
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic          clk,
  input  logic          reset,
  mux_scan_nx1_if.slave bus
);

  localparam int SEL_W = clog2(N_CH);
  localparam int CNT_W = clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_e           state;
  logic [SEL_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             wrap_pend_p0;
  logic [W-1:0]     out_p1;
  logic [SEL_W-1:0] cur_sel_p1;
  logic             wrap_p1;

  logic             scan_act;
  logic             count_en;
  logic             expire;
  logic [SEL_W-1:0] eff_idx;
  logic [SEL_W-1:0] sel_clamped;
  logic [SEL_W-1:0] nxt_idx;
  logic             nxt_wrap;
  logic             blank;
  logic [W-1:0]     mux_y;

  // Scan/hold only drive the index while mode stays high; dropping mode
  // hands the very next output back to sel.
  always_comb begin
    scan_act    = (state != S_MANUAL) && (bus.mode == MODE_SCAN);
    eff_idx     = scan_act ? idx : bus.sel;
    count_en    = scan_act && !bus.hold;
    expire      = count_en && (cnt == CNT_LAST);
    sel_clamped = (int'(bus.sel) < N_CH) ? bus.sel : '0;
  end

`ifdef MUX_SCAN_MASK_EN
  int off;
  int best;

  // Nearest enabled channel strictly after idx in modular order (idx itself
  // counts as a full lap). Landing at or below idx means the search went
  // through channel 0.
  always_comb begin
    nxt_idx  = idx;
    nxt_wrap = 1'b0;
    off      = 0;
    best     = N_CH + 1;
    for (int j = 0; j < N_CH; j++) begin
      off = j - int'(idx);
      if (off <= 0) off = off + N_CH;
      if (bus.ch_mask[j] && (off < best)) begin
        best     = off;
        nxt_idx  = SEL_W'(j);
        nxt_wrap = (j <= int'(idx));
      end
    end
    blank = scan_act && !(|bus.ch_mask);
  end
`else
  always_comb begin
    if (int'(idx) == N_CH - 1) begin
      nxt_idx  = '0;
      nxt_wrap = 1'b1;
    end else begin
      nxt_idx  = idx + SEL_W'(1);
      nxt_wrap = 1'b0;
    end
    blank = 1'b0;
  end
`endif

  mux_nx1 #(
    .N_CH  (N_CH),
    .W     (W),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_bus (bus.in_bus),
    .idx    (eff_idx),
    .y      (mux_y)
  );

  // p0 -> p1: sequencer update and output registers. wrap_pend_p0 marks that
  // the index just rolled over, so wrap lands on the first channel-0 output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_MANUAL;
      idx          <= '0;
      cnt          <= '0;
      wrap_pend_p0 <= 1'b0;
      out_p1       <= '0;
      cur_sel_p1   <= '0;
      wrap_p1      <= 1'b0;
    end else begin
      out_p1       <= blank ? '0 : mux_y;
      cur_sel_p1   <= eff_idx;
      wrap_p1      <= wrap_pend_p0 && scan_act && !blank;
      wrap_pend_p0 <= expire && nxt_wrap;

      unique case (state)
        S_MANUAL: begin
          if (bus.mode == MODE_SCAN) begin
            state <= S_SCAN;
            idx   <= sel_clamped;
            cnt   <= '0;
          end
        end
        S_SCAN, S_HOLD: begin
          if (bus.mode == MODE_MANUAL) state <= S_MANUAL;
          else if (bus.hold)           state <= S_HOLD;
          else                         state <= S_SCAN;
        end
        default: state <= S_MANUAL;
      endcase

      if (count_en) begin
        if (expire) begin
          cnt <= '0;
          idx <= nxt_idx;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.out     = out_p1;
  assign bus.cur_sel = cur_sel_p1;
  assign bus.wrap    = wrap_p1;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1 (N_CH=8, W=4, DWELL=4).
// Expected outputs come from a behavioural model of the scan rules kept in
// this file; directed steps are followed by a randomized phase.
module tb_mux_scan_nx1;

  localparam int N_CH  = 8;
  localparam int W     = 4;
  localparam int DWELL = 4;
  localparam int SEL_W = 3;

  logic clk;
  logic rst;

  mux_scan_nx1_if #(.N_CH(N_CH), .W(W)) bus ();

  mux_scan_nx1 #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]    data [N_CH];
  logic [N_CH-1:0] mask_v;

  // Model state: scanning flag, current channel, elapsed dwell slots, and a
  // flag saying the last advance went round through channel 0.
  bit           m_scan;
  int           m_ch;
  int           m_el;
  bit           m_wpend;
  logic [W-1:0] e_out;
  int           e_cs;
  bit           e_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_CH*W-1:0] pack_data();
    logic [N_CH*W-1:0] v;
    v = '0;
    for (int k = 0; k < N_CH; k++) v[k*W +: W] = data[k];
    return v;
  endfunction

  task automatic model_eval();
    int s;
    int cur;
    s = int'(bus.sel);
    if (rst) begin
      e_out = '0; e_cs = 0; e_wrap = 0;
      m_scan = 0; m_ch = 0; m_el = 0; m_wpend = 0;
      return;
    end
    if (!m_scan || !bus.mode) begin
      e_cs    = s;
      e_out   = (s < N_CH) ? data[s] : '0;
      e_wrap  = 0;
      m_wpend = 0;
      if (!m_scan && bus.mode) begin
        m_scan = 1;
        m_ch   = (s < N_CH) ? s : 0;
        m_el   = 0;
      end else begin
        m_scan = 0;
      end
    end else begin
      e_cs    = m_ch;
      e_out   = (mask_v == 0) ? '0 : data[m_ch];
      e_wrap  = m_wpend && (mask_v != 0);
      m_wpend = 0;
      if (!bus.hold) begin
        m_el++;
        if (m_el == DWELL) begin
          m_el = 0;
          cur  = m_ch;
          for (int k = 1; k <= N_CH; k++) begin
            if (mask_v[(cur + k) % N_CH]) begin
              m_ch = (cur + k) % N_CH;
              if (cur + k >= N_CH) m_wpend = 1;
              break;
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    bus.in_bus = pack_data();
`ifdef MUX_SCAN_MASK_EN
    bus.ch_mask = mask_v;
`endif
    model_eval();
    @(posedge clk);
    #1;
    chk("out", 32'(bus.out), 32'(e_out));
    chk("cur_sel", 32'(bus.cur_sel), 32'(e_cs));
    chk("wrap", 32'(bus.wrap), 32'(e_wrap));
  endtask

  initial begin
    bit found;
    bit order_ok;
    for (int k = 0; k < N_CH; k++) data[k] = W'(k + 1);
    mask_v   = '1;
    rst      = 1'b1;
    bus.mode = 1'b1;
    bus.sel  = '0;
    bus.hold = 1'b0;

    // Reset held two cycles with mode high.
    tick();
    tick();
    chk("reset_out", 32'(bus.out), 0);
    chk("reset_cur_sel", 32'(bus.cur_sel), 0);
    chk("reset_wrap", 32'(bus.wrap), 0);

    // Release with mode still high: the first edge is a manual-state edge.
    rst     = 1'b0;
    bus.sel = 3'd5;
    tick();
    chk("post_reset_manual_out", 32'(bus.out), 6);
    chk("post_reset_manual_cur", 32'(bus.cur_sel), 5);
    bus.mode = 1'b0;
    tick();

    // Manual selection.
    bus.sel = 3'd5;
    tick();
    chk("man5_out", 32'(bus.out), 6);
    chk("man5_cur", 32'(bus.cur_sel), 5);
    bus.sel = 3'd3;
    tick();
    chk("man3_out", 32'(bus.out), 4);
    for (int i = 0; i < 8; i++) begin
      bus.sel = SEL_W'($urandom_range(0, N_CH - 1));
      tick();
    end

    // Scan from channel 0: four cycles per channel, wrap every 32 cycles.
    bus.sel  = '0;
    bus.mode = 1'b1;
    tick();
    for (int n = 0; n < 66; n++) begin
      tick();
      chk("scan_cur_formula", 32'(bus.cur_sel), 32'((n / DWELL) % N_CH));
      chk("scan_wrap_formula", 32'(bus.wrap), 32'((n != 0) && (n % (N_CH * DWELL) == 0)));
    end

    // Hold at channel 2 with one dwell slot spent; channel 2 data changes.
    found = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_scan && m_ch == 2 && m_el == 1) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("reach_ch2", 32'(found), 1);
    bus.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) data[2] = 4'hA;
      tick();
      chk("hold_cur", 32'(bus.cur_sel), 2);
      if (i >= 3) chk("hold_out_live", 32'(bus.out), 32'hA);
    end
    bus.hold = 1'b0;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("hold_release_cur", 32'(bus.cur_sel), (r < 3) ? 2 : 3);
    end

    // Reset while scanning channel 6, then restart from sel with mode high.
    found = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_scan && m_ch == 6) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("reach_ch6", 32'(found), 1);
    rst     = 1'b1;
    bus.sel = 3'd3;
    tick();
    chk("midreset_out", 32'(bus.out), 0);
    chk("midreset_cur", 32'(bus.cur_sel), 0);
    rst = 1'b0;
    tick();
    chk("restart_out", 32'(bus.out), 32'(data[3]));
    chk("restart_cur", 32'(bus.cur_sel), 3);
    for (int i = 0; i < 6; i++) tick();

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N_CH; k++) data[k] = W'($urandom);
      bus.sel  = SEL_W'($urandom);
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      bus.hold = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 63) == 0);
`ifdef MUX_SCAN_MASK_EN
      if ($urandom_range(0, 49) == 0) mask_v = N_CH'($urandom);
`endif
      tick();
    end
    rst      = 1'b0;
    bus.hold = 1'b0;
    for (int k = 0; k < N_CH; k++) data[k] = W'(k + 1);

`ifdef MUX_SCAN_MASK_EN
    // Masked scan visits 0, 2, 7 and wraps back to 0.
    bus.mode = 1'b0;
    tick();
    mask_v   = 8'b1000_0101;
    bus.sel  = '0;
    bus.mode = 1'b1;
    tick();
    order_ok = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!(bus.cur_sel == 0 || bus.cur_sel == 2 || bus.cur_sel == 7)) order_ok = 0;
    end
    chk("mask_order", 32'(order_ok), 1);
    mask_v = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("mask_zero_out", 32'(bus.out), 0);
      chk("mask_zero_wrap", 32'(bus.wrap), 0);
    end
    mask_v = '1;
`else
    order_ok = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (int'(bus.cur_sel) >= N_CH) order_ok = 0;
    end
    chk("index_range", 32'(order_ok), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
